// File: rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv
// rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv - shared widths, FSM encoding and response codes for the read arbiter
package ysyx_22041071_axi_rd_arbiter_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int RESP_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } state_t;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/ysyx_22041071_axi_rd_arbiter_if.sv
// rtl/ysyx_22041071_axi_rd_arbiter_if.sv - AR + R channel bundle shared by IF, MEM and the AXI shim
interface ysyx_22041071_axi_rd_arbiter_if
   import ysyx_22041071_axi_rd_arbiter_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W,
   parameter int RW = RESP_W
);
   logic          ar_valid;
   logic [AW-1:0] ar_addr;
   logic          ar_ready;
   logic          r_valid;
   logic          r_ready;
   logic [DW-1:0] r_data;
   logic [RW-1:0] r_resp;

   modport master (
      output ar_valid, ar_addr, r_ready,
      input  ar_ready, r_valid, r_data, r_resp
   );

   modport slave (
      input  ar_valid, ar_addr, r_ready,
      output ar_ready, r_valid, r_data, r_resp
   );

endinterface

// File: rtl/ysyx_22041071_axi_rd_arbiter_rr_pick.sv
// rtl/ysyx_22041071_axi_rd_arbiter_rr_pick.sv - 2-way round-robin select, bit 1 = MEM, bit 0 = IF
module ysyx_22041071_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       valid
);

   // On a tie the side that did not win last time goes first.
   assign valid = |req;
   assign gnt   = (&req) ? ~last : req[1];

endmodule

// File: rtl/ysyx_22041071_axi_rd_arbiter.sv
// rtl/ysyx_22041071_axi_rd_arbiter.sv - shares one AXI read port between IF and MEM, one transaction at a time
module ysyx_22041071_axi_rd_arbiter
   import ysyx_22041071_axi_rd_arbiter_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            if_flush,
   ysyx_22041071_axi_rd_arbiter_if.slave   if_rd,
   ysyx_22041071_axi_rd_arbiter_if.slave   mem_rd,
   ysyx_22041071_axi_rd_arbiter_if.master  axi_rd
);

   state_t              state;
   state_t              state_n;
   logic                gnt;
   logic                last_gnt;
   logic                drop;
   logic [ADDR_W-1:0]   addr_q;

   logic                pick_gnt;
   logic                pick_valid;
   logic                r_ready_c;
   logic                r_fire;

   ysyx_22041071_rr_pick u_pick (
      .req   ({mem_rd.ar_valid, if_rd.ar_valid & ~if_flush}),
      .last  (last_gnt),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   // A dropped beat is always accepted so the slave never stalls on a cancelled fetch.
   assign r_ready_c = reset && (state == ST_R) &&
                      (drop || ((gnt == GNT_MEM) ? mem_rd.r_ready : if_rd.r_ready));
   assign r_fire    = axi_rd.r_valid & r_ready_c;

   assign axi_rd.r_ready = r_ready_c;
   assign axi_rd.ar_addr = addr_q;
   assign if_rd.r_data   = axi_rd.r_data;
   assign if_rd.r_resp   = axi_rd.r_resp;
   assign mem_rd.r_data  = axi_rd.r_data;
   assign mem_rd.r_resp  = axi_rd.r_resp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         gnt      <= GNT_IF;
         last_gnt <= GNT_IF;
         drop     <= 1'b0;
         addr_q   <= '0;
      end else begin
         state <= state_n;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt    <= pick_gnt;
                  addr_q <= pick_gnt ? mem_rd.ar_addr : if_rd.ar_addr;
               end
            end
            ST_AR: begin
               if (gnt == GNT_IF && if_flush) drop <= 1'b1;
            end
            ST_R: begin
               if (r_fire) begin
                  last_gnt <= gnt;
                  drop     <= 1'b0;
               end else if (gnt == GNT_IF && if_flush) begin
                  drop <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n          = state;
      if_rd.ar_ready   = 1'b0;
      mem_rd.ar_ready  = 1'b0;
      if_rd.r_valid    = 1'b0;
      mem_rd.r_valid   = 1'b0;
      axi_rd.ar_valid  = 1'b0;
      if (reset) begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_n         = ST_AR;
                  if_rd.ar_ready  = ~pick_gnt;
                  mem_rd.ar_ready = pick_gnt;
               end
            end
            ST_AR: begin
               // Held until accepted, even across a flush: AR may not be withdrawn.
               axi_rd.ar_valid = 1'b1;
               if (axi_rd.ar_ready) state_n = ST_R;
            end
            ST_R: begin
               if (gnt == GNT_MEM) mem_rd.r_valid = axi_rd.r_valid & ~drop;
               else                if_rd.r_valid  = axi_rd.r_valid & ~drop & ~if_flush;
               if (r_fire) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arbiter.sv
// tb/tb_ysyx_22041071_axi_rd_arbiter.sv - directed self-checking bench for the AXI read arbiter
module tb_ysyx_22041071_axi_rd_arbiter;
   import ysyx_22041071_axi_rd_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic if_flush = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   ysyx_22041071_axi_rd_arbiter_if if_rd  ();
   ysyx_22041071_axi_rd_arbiter_if mem_rd ();
   ysyx_22041071_axi_rd_arbiter_if axi_rd ();

   ysyx_22041071_axi_rd_arbiter u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .if_flush (if_flush),
      .if_rd    (if_rd),
      .mem_rd   (mem_rd),
      .axi_rd   (axi_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one transaction from IDLE with the requests already driven; the slave answers with ready=1.
   task automatic txn(input string tag, input bit exp_mem, input logic [63:0] exp_addr,
                      input logic [63:0] rdata, input logic [1:0] rresp, input int ar_wait);
      #1;
      chk({tag, ".win_ar_ready"},  64'(exp_mem ? mem_rd.ar_ready : if_rd.ar_ready), 64'd1);
      chk({tag, ".lose_ar_ready"}, 64'(exp_mem ? if_rd.ar_ready : mem_rd.ar_ready), 64'd0);
      tick;
      if (exp_mem) mem_rd.ar_valid = 1'b0;
      else         if_rd.ar_valid  = 1'b0;
      for (int i = 0; i < ar_wait; i++) begin
         #1;
         chk({tag, ".ar_valid_wait"}, 64'(axi_rd.ar_valid), 64'd1);
         tick;
      end
      axi_rd.ar_ready = 1'b1;
      #1;
      chk({tag, ".ar_valid"}, 64'(axi_rd.ar_valid), 64'd1);
      chk({tag, ".ar_addr"},  axi_rd.ar_addr, exp_addr);
      tick;
      axi_rd.ar_ready = 1'b0;
      axi_rd.r_valid  = 1'b1;
      axi_rd.r_data   = rdata;
      axi_rd.r_resp   = rresp;
      #1;
      chk({tag, ".win_r_valid"},  64'(exp_mem ? mem_rd.r_valid : if_rd.r_valid), 64'd1);
      chk({tag, ".lose_r_valid"}, 64'(exp_mem ? if_rd.r_valid : mem_rd.r_valid), 64'd0);
      chk({tag, ".r_data"}, exp_mem ? mem_rd.r_data : if_rd.r_data, rdata);
      chk({tag, ".r_resp"}, 64'(exp_mem ? mem_rd.r_resp : if_rd.r_resp), 64'(rresp));
      chk({tag, ".axi_r_ready"}, 64'(axi_rd.r_ready), 64'd1);
      tick;
      axi_rd.r_valid = 1'b0;
      #1;
      chk({tag, ".idle_ar_valid"}, 64'(axi_rd.ar_valid), 64'd0);
      chk({tag, ".idle_r_valid"},  64'(exp_mem ? mem_rd.r_valid : if_rd.r_valid), 64'd0);
   endtask

   initial begin
      if_rd.ar_valid  = 1'b1;
      if_rd.ar_addr   = '0;
      if_rd.r_ready   = 1'b0;
      mem_rd.ar_valid = 1'b0;
      mem_rd.ar_addr  = '0;
      mem_rd.r_ready  = 1'b0;
      axi_rd.ar_ready = 1'b0;
      axi_rd.r_valid  = 1'b0;
      axi_rd.r_data   = '0;
      axi_rd.r_resp   = '0;

      // reset holds every handshake output low even with a request pending
      repeat (2) @(posedge clk);
      #1;
      chk("rst.if_ar_ready",  64'(if_rd.ar_ready), 64'd0);
      chk("rst.axi_ar_valid", 64'(axi_rd.ar_valid), 64'd0);
      chk("rst.axi_r_ready",  64'(axi_rd.r_ready), 64'd0);
      chk("rst.if_r_valid",   64'(if_rd.r_valid), 64'd0);
      if_rd.ar_valid = 1'b0;
      if_rd.r_ready  = 1'b1;
      mem_rd.r_ready = 1'b1;
      rst_n = 1'b1;
      tick;

      // IF alone, slave AR ready after 2 cycles
      if_rd.ar_valid = 1'b1;
      if_rd.ar_addr  = 64'h8000_0000;
      txn("t1", 1'b0, 64'h8000_0000, 64'h0000_0013_0010_0093, RESP_OKAY, 2);

      // tie from reset goes to MEM, then alternates
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick;
      if_rd.ar_valid  = 1'b1;
      if_rd.ar_addr   = 64'h8000_0004;
      mem_rd.ar_valid = 1'b1;
      mem_rd.ar_addr  = 64'h8000_1000;
      txn("t2a", 1'b1, 64'h8000_1000, 64'h1111, RESP_OKAY, 0);
      txn("t2b", 1'b0, 64'h8000_0004, 64'h2222, RESP_OKAY, 1);
      if_rd.ar_valid  = 1'b1;
      if_rd.ar_addr   = 64'h8000_0008;
      mem_rd.ar_valid = 1'b1;
      mem_rd.ar_addr  = 64'h8000_1008;
      txn("t2c", 1'b1, 64'h8000_1008, 64'h2c2c, RESP_OKAY, 0);
      mem_rd.ar_valid = 1'b1;
      mem_rd.ar_addr  = 64'h8000_1010;
      txn("t2d", 1'b0, 64'h8000_0008, 64'h2d2d, RESP_OKAY, 0);
      txn("t2e", 1'b1, 64'h8000_1010, 64'h2e2e, RESP_OKAY, 0);

      // flush during AR: request stays up, beat swallowed internally
      if_rd.ar_valid = 1'b1;
      if_rd.ar_addr  = 64'h8000_0010;
      #1;
      chk("t3.if_ar_ready", 64'(if_rd.ar_ready), 64'd1);
      tick;
      if_rd.ar_valid = 1'b0;
      if_flush       = 1'b1;
      #1;
      chk("t3.ar_valid_flush", 64'(axi_rd.ar_valid), 64'd1);
      tick;
      if_flush = 1'b0;
      #1;
      chk("t3.ar_valid_held", 64'(axi_rd.ar_valid), 64'd1);
      chk("t3.ar_addr", axi_rd.ar_addr, 64'h8000_0010);
      axi_rd.ar_ready = 1'b1;
      tick;
      axi_rd.ar_ready = 1'b0;
      if_rd.r_ready   = 1'b0;
      axi_rd.r_valid  = 1'b1;
      axi_rd.r_data   = 64'hdead;
      #1;
      chk("t3.axi_r_ready", 64'(axi_rd.r_ready), 64'd1);
      chk("t3.if_r_valid",  64'(if_rd.r_valid), 64'd0);
      tick;
      axi_rd.r_valid = 1'b0;
      if_rd.r_ready  = 1'b1;
      #1;
      chk("t3.idle_ar_valid", 64'(axi_rd.ar_valid), 64'd0);
      chk("t3.idle_r_valid",  64'(if_rd.r_valid), 64'd0);

      // flush in IDLE only masks the IF request
      if_flush       = 1'b1;
      if_rd.ar_valid = 1'b1;
      if_rd.ar_addr  = 64'h8000_0014;
      #1;
      chk("t3.idle_flush_ready", 64'(if_rd.ar_ready), 64'd0);
      tick;
      #1;
      chk("t3.idle_flush_stay", 64'(axi_rd.ar_valid), 64'd0);
      if_flush = 1'b0;
      txn("t3b", 1'b0, 64'h8000_0014, 64'h3333, RESP_OKAY, 0);

      // MEM back-pressure on R; IF waits without a grant
      mem_rd.ar_valid = 1'b1;
      mem_rd.ar_addr  = 64'h8000_2000;
      #1;
      chk("t4.mem_ar_ready", 64'(mem_rd.ar_ready), 64'd1);
      tick;
      mem_rd.ar_valid = 1'b0;
      axi_rd.ar_ready = 1'b1;
      #1;
      chk("t4.ar_addr", axi_rd.ar_addr, 64'h8000_2000);
      tick;
      axi_rd.ar_ready = 1'b0;
      mem_rd.r_ready  = 1'b0;
      axi_rd.r_valid  = 1'b1;
      axi_rd.r_data   = 64'h4444;
      axi_rd.r_resp   = RESP_OKAY;
      if_rd.ar_valid  = 1'b1;
      if_rd.ar_addr   = 64'h8000_0018;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4.axi_r_ready_wait", 64'(axi_rd.r_ready), 64'd0);
         chk("t4.if_ar_ready_wait", 64'(if_rd.ar_ready), 64'd0);
         chk("t4.mem_r_valid_wait", 64'(mem_rd.r_valid), 64'd1);
         tick;
      end
      mem_rd.r_ready = 1'b1;
      #1;
      chk("t4.axi_r_ready", 64'(axi_rd.r_ready), 64'd1);
      chk("t4.mem_r_data",  mem_rd.r_data, 64'h4444);
      tick;
      axi_rd.r_valid = 1'b0;
      txn("t4b", 1'b0, 64'h8000_0018, 64'h5555, RESP_OKAY, 0);

      // SLVERR forwarded, no re-issue
      mem_rd.ar_valid = 1'b1;
      mem_rd.ar_addr  = 64'h8000_3000;
      txn("t5", 1'b1, 64'h8000_3000, 64'h6666, RESP_SLVERR, 1);
      tick;
      chk("t5.no_reissue", 64'(axi_rd.ar_valid), 64'd0);

      // reset in R clears outputs at once; normal service afterwards
      if_rd.ar_valid = 1'b1;
      if_rd.ar_addr  = 64'h8000_001c;
      tick;
      if_rd.ar_valid  = 1'b0;
      axi_rd.ar_ready = 1'b1;
      tick;
      axi_rd.ar_ready = 1'b0;
      axi_rd.r_valid  = 1'b1;
      axi_rd.r_data   = 64'h7070;
      #1;
      chk("t6.if_r_valid_pre", 64'(if_rd.r_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6.if_r_valid_rst",  64'(if_rd.r_valid), 64'd0);
      chk("t6.axi_r_ready_rst", 64'(axi_rd.r_ready), 64'd0);
      chk("t6.ar_valid_rst",    64'(axi_rd.ar_valid), 64'd0);
      tick;
      rst_n          = 1'b1;
      axi_rd.r_valid = 1'b0;
      if_rd.ar_valid = 1'b1;
      if_rd.ar_addr  = 64'h8000_0020;
      txn("t6b", 1'b0, 64'h8000_0020, 64'h7777, RESP_OKAY, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
